tdm_demux_1x8: RTL

TDM_DEMUX_1X8 -- requirements
Module: tdm_demux_1x8

---
 rtl/tdm_demux_1x8.sv | 94 +++++++++
 1 files changed

// File: rtl/tdm_demux_1x8.sv
// 1:8 TDM demultiplexer: collects an 8-slot serial frame, qualified by en and aligned by sof,
// and presents it on registered parallel outputs with frame_valid / frame_err pulses.
module tdm_demux_1x8 (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic sof,
    input  logic en,
    output logic o0,
    output logic o1,
    output logic o2,
    output logic o3,
    output logic o4,
    output logic o5,
    output logic o6,
    output logic o7,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic frame_valid,
    output logic frame_err
);

    typedef enum logic [0:0] {
        StIdle,
        StRecv
    } state_e;

    state_e      state_q;
    logic [2:0]  slot_q;
    logic [7:0]  shadow_q;
    logic [7:0]  out_q;
    logic        valid_q;
    logic        err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            slot_q   <= 3'd0;
            shadow_q <= 8'h00;
            out_q    <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (en) begin
                unique case (state_q)
                    StIdle: begin
                        if (sof) begin
                            shadow_q <= {7'b0, din};
                            slot_q   <= 3'd1;
                            state_q  <= StRecv;
                        end
                    end
                    StRecv: begin
                        // A sof inside a frame aborts it and restarts at slot 0 with this bit.
                        if (sof) begin
                            shadow_q <= {7'b0, din};
                            slot_q   <= 3'd1;
                            err_q    <= 1'b1;
                        end else if (slot_q == 3'd7) begin
                            out_q   <= {din, shadow_q[6:0]};
                            valid_q <= 1'b1;
                            slot_q  <= 3'd0;
                            state_q <= StIdle;
                        end else begin
                            shadow_q[slot_q] <= din;
                            slot_q           <= slot_q + 3'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign o0 = out_q[0];
    assign o1 = out_q[1];
    assign o2 = out_q[2];
    assign o3 = out_q[3];
    assign o4 = out_q[4];
    assign o5 = out_q[5];
    assign o6 = out_q[6];
    assign o7 = out_q[7];

    assign s0 = slot_q[0];
    assign s1 = slot_q[1];
    assign s2 = slot_q[2];

    assign frame_valid = valid_q;
    assign frame_err   = err_q;

endmodule
